// File: rtl/opc2_boot_loader_if.sv
// Boot loader port bundle: byte-stream handshake, CPU memory request,
// shared memory port and loader status.
interface opc2_boot_loader_if;
    logic       load_start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       cpu_reset_b;
    logic [9:0] cpu_address;
    logic       cpu_rnw;
    logic [7:0] cpu_wdata;
    logic [9:0] mem_address;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       done;
    logic       error;

    // Host / CPU / memory side
    modport master (
        output load_start, rx_data, rx_valid, cpu_address, cpu_rnw, cpu_wdata,
        input  rx_ready, cpu_reset_b, mem_address, mem_we, mem_wdata, busy, done, error
    );

    // Loader side
    modport slave (
        input  load_start, rx_data, rx_valid, cpu_address, cpu_rnw, cpu_wdata,
        output rx_ready, cpu_reset_b, mem_address, mem_we, mem_wdata, busy, done, error
    );
endinterface

// File: rtl/opc2_boot_loader.sv
// OPC2 boot loader: receives a length-prefixed image over a byte stream,
// writes it to memory from LOAD_BASE, checks an optional 8-bit sum and
// releases the CPU from reset once the image is accepted.
module opc2_boot_loader #(
    parameter logic [9:0] LOAD_BASE = 10'h100,
    parameter bit         CSUM_EN   = 1'b1
) (
    input  logic               clk,
    input  logic               reset_b,
    opc2_boot_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERROR
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] len_hi_q;
    logic [9:0] remain_q;
    logic [7:0] sum_q;
    logic [9:0] ptr_q;
    logic       ld_we_q;
    logic [9:0] ld_addr_q;
    logic [7:0] ld_wdata_q;
    logic       rx_ready_q;
    logic       cpu_reset_b_q;
    logic       busy_q;
    logic       done_q;
    logic       error_q;
    logic       xfer;

    // Next-state decode; a transfer is only possible in a receiving state
    always_comb begin
        xfer    = bus.rx_valid && rx_ready_q;
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.load_start) state_d = S_LEN_HI;
            S_LEN_HI: if (xfer) state_d = S_LEN_LO;
            S_LEN_LO: begin
                if (xfer) begin
                    if ({len_hi_q, bus.rx_data} == 10'd0)
                        state_d = CSUM_EN ? S_CSUM : S_RUN;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA:   if (xfer && remain_q == 10'd1) state_d = CSUM_EN ? S_CSUM : S_RUN;
            S_CSUM:   if (xfer) state_d = (bus.rx_data == sum_q) ? S_RUN : S_ERROR;
            S_RUN,
            S_ERROR:  if (bus.load_start) state_d = S_LEN_HI;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM, datapath and registered outputs. rx_ready follows the next state so
    // it is high exactly while receiving; status lags the state by one cycle,
    // which lets the final data write land before done hands the port over.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q       <= S_IDLE;
            len_hi_q      <= '0;
            remain_q      <= '0;
            sum_q         <= '0;
            ptr_q         <= LOAD_BASE;
            ld_we_q       <= 1'b0;
            ld_addr_q     <= '0;
            ld_wdata_q    <= '0;
            rx_ready_q    <= 1'b0;
            cpu_reset_b_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_ready_q    <= state_d inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
            busy_q        <= state_q inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
            done_q        <= (state_q == S_RUN);
            cpu_reset_b_q <= (state_q == S_RUN);
            error_q       <= (state_q == S_ERROR);
            ld_we_q       <= 1'b0;
            if (xfer) begin
                case (state_q)
                    S_LEN_HI: len_hi_q <= bus.rx_data[1:0];
                    S_LEN_LO: begin
                        remain_q <= {len_hi_q, bus.rx_data};
                        sum_q    <= '0;
                        ptr_q    <= LOAD_BASE;
                    end
                    S_DATA: begin
                        ld_we_q    <= 1'b1;
                        ld_addr_q  <= ptr_q;
                        ld_wdata_q <= bus.rx_data;
                        sum_q      <= sum_q + bus.rx_data;
                        ptr_q      <= ptr_q + 10'd1;
                        remain_q   <= remain_q - 10'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Memory port: CPU pass-through while running, loader otherwise
    always_comb begin
        bus.rx_ready    = rx_ready_q;
        bus.cpu_reset_b = cpu_reset_b_q;
        bus.busy        = busy_q;
        bus.done        = done_q;
        bus.error       = error_q;
        if (done_q) begin
            bus.mem_address = bus.cpu_address;
            bus.mem_wdata   = bus.cpu_wdata;
            bus.mem_we      = ~bus.cpu_rnw;
        end else begin
            bus.mem_address = ld_addr_q;
            bus.mem_wdata   = ld_wdata_q;
            bus.mem_we      = ld_we_q;
        end
    end

endmodule

// File: tb/tb_opc2_boot_loader.sv
// Testbench for opc2_boot_loader: three instances (checksum on, checksum off,
// base near the top of memory) share one stimulus port selected by 'sel'.
module tb_opc2_boot_loader;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed { logic [9:0] a; logic [7:0] d; } wr_t;

    logic       clk = 1'b0;
    logic       reset_b;
    logic       load_start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [9:0] cpu_address;
    logic       cpu_rnw;
    logic [7:0] cpu_wdata;
    int         sel;

    logic       rx_ready_m, cpu_reset_b_m, mem_we_m, busy_m, done_m, error_m;
    logic [9:0] mem_address_m;
    logic [7:0] mem_wdata_m;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    opc2_boot_loader_if bus0 ();
    opc2_boot_loader_if bus1 ();
    opc2_boot_loader_if bus2 ();

    assign bus0.load_start  = (sel == 0) ? load_start : 1'b0;
    assign bus0.rx_valid    = (sel == 0) ? rx_valid : 1'b0;
    assign bus0.rx_data     = rx_data;
    assign bus0.cpu_address = cpu_address;
    assign bus0.cpu_rnw     = cpu_rnw;
    assign bus0.cpu_wdata   = cpu_wdata;
    assign bus1.load_start  = (sel == 1) ? load_start : 1'b0;
    assign bus1.rx_valid    = (sel == 1) ? rx_valid : 1'b0;
    assign bus1.rx_data     = rx_data;
    assign bus1.cpu_address = cpu_address;
    assign bus1.cpu_rnw     = cpu_rnw;
    assign bus1.cpu_wdata   = cpu_wdata;
    assign bus2.load_start  = (sel == 2) ? load_start : 1'b0;
    assign bus2.rx_valid    = (sel == 2) ? rx_valid : 1'b0;
    assign bus2.rx_data     = rx_data;
    assign bus2.cpu_address = cpu_address;
    assign bus2.cpu_rnw     = cpu_rnw;
    assign bus2.cpu_wdata   = cpu_wdata;

    opc2_boot_loader #(.LOAD_BASE(10'h100), .CSUM_EN(1'b1)) u_dut0 (.clk(clk), .reset_b(reset_b), .bus(bus0));
    opc2_boot_loader #(.LOAD_BASE(10'h100), .CSUM_EN(1'b0)) u_dut1 (.clk(clk), .reset_b(reset_b), .bus(bus1));
    opc2_boot_loader #(.LOAD_BASE(10'h3FE), .CSUM_EN(1'b1)) u_dut2 (.clk(clk), .reset_b(reset_b), .bus(bus2));

    always_comb begin
        case (sel)
            1: {rx_ready_m, cpu_reset_b_m, mem_we_m, busy_m, done_m, error_m, mem_address_m, mem_wdata_m} =
                   {bus1.rx_ready, bus1.cpu_reset_b, bus1.mem_we, bus1.busy, bus1.done, bus1.error, bus1.mem_address, bus1.mem_wdata};
            2: {rx_ready_m, cpu_reset_b_m, mem_we_m, busy_m, done_m, error_m, mem_address_m, mem_wdata_m} =
                   {bus2.rx_ready, bus2.cpu_reset_b, bus2.mem_we, bus2.busy, bus2.done, bus2.error, bus2.mem_address, bus2.mem_wdata};
            default: {rx_ready_m, cpu_reset_b_m, mem_we_m, busy_m, done_m, error_m, mem_address_m, mem_wdata_m} =
                   {bus0.rx_ready, bus0.cpu_reset_b, bus0.mem_we, bus0.busy, bus0.done, bus0.error, bus0.mem_address, bus0.mem_wdata};
        endcase
    end

    // Monitor: loader-owned writes (CPU still in reset) and cpu_reset_b rises
    wr_t  wr_q[$];
    int   cyc = 0;
    int   last_we_cyc = -1;
    int   rise_cyc = -1;
    logic prev_crb = 1'b0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mem_we_m === 1'b1 && cpu_reset_b_m !== 1'b1) begin
            wr_q.push_back({mem_address_m, mem_wdata_m});
            last_we_cyc <= cyc;
        end
        if (cpu_reset_b_m === 1'b1 && prev_crb !== 1'b1) rise_cyc <= cyc;
        prev_crb <= cpu_reset_b_m;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Full load on instance s; expectations come from the image itself
    task automatic run_load(input int s, input logic [9:0] base, input bit csum_en,
                            input byte_q_t data, input logic [7:0] csum,
                            input int unsigned stall_pct, input int ls_at, input string name);
        byte_q_t     stream;
        wr_t         exp[$];
        logic [9:0]  len;
        logic [7:0]  r;
        int          sum;
        bit          good;
        int          w0, c0, waited, nw;
        sel = s;
        step();
        w0  = wr_q.size();
        c0  = cyc;
        len = 10'(data.size());
        r   = 8'($urandom);
        stream.push_back({r[7:2], len[9:8]});
        stream.push_back(len[7:0]);
        sum = 0;
        foreach (data[i]) begin
            stream.push_back(data[i]);
            sum = (sum + int'(data[i])) % 256;
            exp.push_back({10'((int'(base) + i) % 1024), data[i]});
        end
        if (csum_en) stream.push_back(csum);
        good = !csum_en || (int'(csum) == sum);

        // load_start with a byte already offered: nothing may be taken that cycle
        load_start = 1'b1;
        rx_valid   = 1'b1;
        rx_data    = stream[0];
        n_checks++;
        if (rx_ready_m !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ready_at_start: got %b, expected 0", name, rx_ready_m);
        end
        step();
        load_start = 1'b0;

        foreach (stream[i]) begin
            if ($urandom_range(99) < stall_pct) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                repeat ($urandom_range(1, 3)) step();
            end
            rx_valid = 1'b1;
            rx_data  = stream[i];
            if (i == ls_at) load_start = 1'b1;
            waited = 0;
            while (rx_ready_m !== 1'b1 && waited < 20) begin
                step();
                load_start = 1'b0;
                waited++;
            end
            if (waited >= 20) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s ready_timeout: byte %0d not accepted within 20 cycles", name, i);
                break;
            end
            step();
            load_start = 1'b0;
        end
        rx_valid = 1'b0;
        repeat (3) step();

        nw = wr_q.size() - w0;
        n_checks++;
        if (nw != exp.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d, expected %0d", name, nw, exp.size());
        end
        for (int i = 0; i < exp.size() && i < nw; i++) begin
            n_checks++;
            if (wr_q[w0 + i] !== exp[i]) begin
                n_fail++;
                $display("FAIL %s write[%0d]: got addr %h data %h, expected addr %h data %h",
                         name, i, wr_q[w0 + i].a, wr_q[w0 + i].d, exp[i].a, exp[i].d);
            end
        end
        n_checks++;
        if ({done_m, error_m, cpu_reset_b_m, busy_m, rx_ready_m} !== {good, !good, good, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s status: got done/err/crb/busy/rdy %b%b%b%b%b, expected %b%b%b00",
                     name, done_m, error_m, cpu_reset_b_m, busy_m, rx_ready_m, good, !good, good);
        end
        if (good && exp.size() > 0) begin
            n_checks++;
            if (!(rise_cyc > c0 && rise_cyc > last_we_cyc)) begin
                n_fail++;
                $display("FAIL %s release_order: cpu_reset_b rise cycle %0d, last write cycle %0d",
                         name, rise_cyc, last_we_cyc);
            end
        end
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        #2;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            n_checks++;
            if ({rx_ready_m, cpu_reset_b_m, mem_we_m, busy_m, done_m, error_m} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got %b, expected 000000", s,
                         {rx_ready_m, cpu_reset_b_m, mem_we_m, busy_m, done_m, error_m});
            end
        end
        sel = 0;
        repeat (2) step();
        reset_b = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [9:0] a;
        logic [7:0] d;
        run_load(0, 10'h100, 1'b1, '{8'hA1, 8'hB2, 8'hC3}, 8'h16, 0, -1, "basic");
        for (int k = 0; k < 4; k++) begin
            a = 10'($urandom);
            d = 8'($urandom);
            cpu_address = a;
            cpu_wdata   = d;
            cpu_rnw     = k[0];
            #1;
            n_checks++;
            if ({mem_address_m, mem_wdata_m, mem_we_m} !== {a, d, ~k[0]}) begin
                n_fail++;
                $display("FAIL passthru[%0d]: got %h/%h/%b, expected %h/%h/%b",
                         k, mem_address_m, mem_wdata_m, mem_we_m, a, d, ~k[0]);
            end
        end
        cpu_rnw = 1'b1;
        step();
    endtask

    task automatic test_bad_csum();
        run_load(0, 10'h100, 1'b1, '{8'hA1, 8'hB2, 8'hC3}, 8'h17, 0, -1, "bad_csum");
        cpu_rnw     = 1'b0;
        cpu_address = 10'h2A5;
        #1;
        n_checks++;
        if (mem_we_m !== 1'b0) begin
            n_fail++;
            $display("FAIL error_no_passthru: mem_we got %b, expected 0", mem_we_m);
        end
        cpu_rnw = 1'b1;
        step();
        run_load(0, 10'h100, 1'b1, '{8'h10, 8'h20}, 8'h30, 0, -1, "reload_good");
    endtask

    task automatic test_zero_len();
        byte_q_t empty;
        run_load(0, 10'h100, 1'b1, empty, 8'h00, 0, -1, "zero_csum");
        run_load(1, 10'h100, 1'b0, empty, 8'h00, 0, -1, "zero_nocsum");
    endtask

    task automatic test_wrap();
        run_load(2, 10'h3FE, 1'b1, '{8'h01, 8'h02, 8'h03}, 8'h06, 0, -1, "wrap");
    endtask

    task automatic test_random_stall();
        byte_q_t    d;
        int         len, s, sum;
        string      nm;
        for (int k = 0; k < 6; k++) begin
            d.delete();
            s   = k % 2;
            len = $urandom_range(1, 40);
            sum = 0;
            for (int i = 0; i < len; i++) begin
                d.push_back(8'($urandom));
                sum = (sum + int'(d[i])) % 256;
            end
            if (k == 4) sum = sum ^ 8'h5A;
            nm = $sformatf("random%0d", k);
            run_load(s, 10'h100, (s == 0), d, 8'(sum), 40, 2 + len / 2, nm);
        end
    endtask

    task automatic test_reset_midload();
        byte_q_t stream;
        int      waited;
        sel = 0;
        step();
        stream = '{8'h00, 8'h04, 8'h5C, 8'h7E};
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        foreach (stream[i]) begin
            rx_valid = 1'b1;
            rx_data  = stream[i];
            waited = 0;
            while (rx_ready_m !== 1'b1 && waited < 20) begin
                step();
                waited++;
            end
            step();
        end
        rx_valid = 1'b0;
        reset_b  = 1'b0;
        #1;
        n_checks++;
        if ({rx_ready_m, cpu_reset_b_m, mem_we_m, busy_m, done_m, error_m} !== 6'b0) begin
            n_fail++;
            $display("FAIL midload_reset: got %b, expected 000000",
                     {rx_ready_m, cpu_reset_b_m, mem_we_m, busy_m, done_m, error_m});
        end
        step();
        reset_b = 1'b1;
        step();
        run_load(0, 10'h100, 1'b1, '{8'h11, 8'h22, 8'h33}, 8'h66, 20, -1, "after_reset");
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_b     = 1'b0;
        load_start  = 1'b0;
        rx_data     = '0;
        rx_valid    = 1'b0;
        cpu_address = '0;
        cpu_rnw     = 1'b1;
        cpu_wdata   = '0;
        sel         = 0;
        test_reset();
        test_basic();
        test_bad_csum();
        test_zero_len();
        test_wrap();
        test_random_stall();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
